// File: rtl/qam_bist_pkg.sv
// qam_bist_pkg: shared types, PRBS-15 constants and helpers
// for the QAM loopback BIST (qam_link_bist, qam_ref_fifo).
package qam_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [14:0] PRBS15_SEED = 15'h7FFF;
  // x^15 + x^14 + 1
  localparam int PRBS15_TAP_A = 15;
  localparam int PRBS15_TAP_B = 14;
  localparam int DRAIN_TIMEOUT = 1024;

  // Shift n new bits in at the LSB end; oldest bit leaves at the MSB.
  function automatic logic [14:0] prbs_step(
    input logic [14:0] s,
    input int          n
  );
    logic [14:0] r;
    r = s;
    for (int i = 0; i < 15; i++) begin
      if (i < n) begin
        r = {r[13:0], r[PRBS15_TAP_A-1] ^ r[PRBS15_TAP_B-1]};
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/qam_ref_fifo.sv
// qam_ref_fifo: synchronous reference FIFO of sent symbols.
// Ports: clk, rst/clr (empty it), push/wdata, pop/rdata (head), full, empty.
module qam_ref_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  // A pop on empty is dropped; a push on full only lands
  // when a pop frees the head slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/qam_link_bist.sv
// qam_link_bist: PRBS-15 symbol source and decision checker for the QAM loopback.
// Ports: axi_clk/axi_rst, start/num_syms, mod_* (to modulator), dec_* (from slicer),
// busy/done, sym_count/sym_err/bit_err, orphan. Macro QAM_LINK_BIST_ERRINJ_EN
// adds inject_err/inj_count for deliberate LSB corruption of sent symbols.
module qam_link_bist
  import qam_bist_pkg::*;
#(
  parameter int BITS_PER_SYM = 4,
  parameter int FIFO_DEPTH   = 64,
  parameter int CNT_W        = 32,
  parameter int SKIP_SYMS    = 8
) (
  input  logic                           axi_clk,
  input  logic                           axi_rst,
  input  logic                           start,
`ifdef QAM_LINK_BIST_ERRINJ_EN
  input  logic                           inject_err,
  output logic [CNT_W-1:0]               inj_count,
`endif
  input  logic [CNT_W-1:0]               num_syms,
  output logic                           mod_valid,
  output logic signed [BITS_PER_SYM-1:0] mod_data,
  input  logic                           mod_ready,
  input  logic                           dec_valid,
  input  logic [BITS_PER_SYM-1:0]        dec_data,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_W-1:0]               sym_count,
  output logic [CNT_W-1:0]               sym_err,
  output logic [CNT_W-1:0]               bit_err,
  output logic                           orphan
);

  localparam int B      = BITS_PER_SYM;
  localparam int SKIP_W = $clog2(SKIP_SYMS + 1) + 1;
  localparam logic [10:0] TMO_LAST = 11'(DRAIN_TIMEOUT - 1);

  state_t            state;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  sent;
  logic [14:0]       prbs;
  logic [10:0]       tmo;
  logic [SKIP_W-1:0] skip_cnt;

  logic          clr;
  logic          active;
  logic          hs;
  logic          fifo_full;
  logic          fifo_empty;
  logic          dec_hit;
  logic [B-1:0]  head;
  logic [B-1:0]  sym;
  logic [B-1:0]  diff;
  logic [3:0]    nbits;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign clr     = (state == IDLE) && start;
  assign active  = (state == RUN) || (state == DRAIN);
  assign sym     = prbs[B-1:0];
  assign mod_valid = (state == RUN) && (sent < num_q) && !fifo_full;
  assign hs      = mod_valid && mod_ready;
  assign dec_hit = active && dec_valid && !fifo_empty;
  assign diff    = head ^ dec_data;
  assign nbits   = popcount(8'(diff));

`ifdef QAM_LINK_BIST_ERRINJ_EN
  logic armed;
  logic [B-1:0] lsb;

  assign lsb = B'(1);
  assign mod_data = mod_valid ? (sym ^ (armed ? lsb : '0)) : '0;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      armed     <= 1'b0;
      inj_count <= '0;
    end else begin
      if (inject_err)  armed <= 1'b1;
      else if (hs)     armed <= 1'b0;
      if (clr)
        inj_count <= '0;
      else if (hs && armed)
        inj_count <= sat_add(inj_count, CNT_W'(1));
    end
  end
`else
  assign mod_data = mod_valid ? sym : '0;
`endif

  // The FIFO always stores the clean PRBS symbol.
  qam_ref_fifo #(
    .W     (B),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (axi_clk),
    .rst   (axi_rst),
    .clr   (clr),
    .push  (hs),
    .wdata (sym),
    .pop   (dec_hit),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge axi_clk) begin
    if (axi_rst || clr) begin
      prbs <= PRBS15_SEED;
      sent <= '0;
    end else if (hs) begin
      prbs <= prbs_step(prbs, B);
      sent <= sent + CNT_W'(1);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst || clr) begin
      sym_count <= '0;
      sym_err   <= '0;
      bit_err   <= '0;
      orphan    <= 1'b0;
      skip_cnt  <= '0;
    end else if (active && dec_valid) begin
      if (fifo_empty) begin
        orphan <= 1'b1;
      end else if (skip_cnt < SKIP_W'(SKIP_SYMS)) begin
        skip_cnt <= skip_cnt + SKIP_W'(1);
      end else begin
        sym_count <= sat_add(sym_count, CNT_W'(1));
        if (diff != '0) begin
          sym_err <= sat_add(sym_err, CNT_W'(1));
          bit_err <= sat_add(bit_err, CNT_W'(nbits));
        end
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      num_q <= '0;
      tmo   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            num_q <= num_syms;
            if (num_syms == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (sent == num_q) begin
            state <= DRAIN;
            tmo   <= '0;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (dec_valid) begin
            tmo <= '0;
          end else if (tmo == TMO_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            tmo <= tmo + 11'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qam_link_bist.sv
// tb_qam_link_bist: random-stimulus bench for qam_link_bist with a
// bit-stream PRBS model, a behavioural loopback channel and a scoreboard.
module tb_qam_link_bist;

  localparam int B     = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int SKIP  = 8;
  localparam int LAT   = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_syms;
  logic          mod_valid;
  logic [B-1:0]  mod_data;
  logic          mod_ready;
  logic          dec_valid;
  logic [B-1:0]  dec_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] sym_count;
  logic [CW-1:0] sym_err;
  logic [CW-1:0] bit_err;
  logic          orphan;
`ifdef QAM_LINK_BIST_ERRINJ_EN
  logic          inject_err;
  logic [CW-1:0] inj_count;
`endif

  always #5 clk = ~clk;

  qam_link_bist #(
    .BITS_PER_SYM (B),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (CW),
    .SKIP_SYMS    (SKIP)
  ) dut (
    .axi_clk   (clk),
    .axi_rst   (rst),
    .start     (start),
`ifdef QAM_LINK_BIST_ERRINJ_EN
    .inject_err(inject_err),
    .inj_count (inj_count),
`endif
    .num_syms  (num_syms),
    .mod_valid (mod_valid),
    .mod_data  (mod_data),
    .mod_ready (mod_ready),
    .dec_valid (dec_valid),
    .dec_data  (dec_data),
    .busy      (busy),
    .done      (done),
    .sym_count (sym_count),
    .sym_err   (sym_err),
    .bit_err   (bit_err),
    .orphan    (orphan)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // PRBS-15 as a plain bit stream: b[n] = b[n-15] ^ b[n-14],
  // with every bit before n = 0 equal to 1 (all-ones seed).
  bit pb [0:8191];

  function automatic bit bitv(input int i);
    return (i < 0) ? 1'b1 : pb[i];
  endfunction

  // Symbol k is the B bits ending at stream position k*B, oldest first.
  function automatic logic [B-1:0] sym_at(input int k);
    logic [B-1:0] r;
    r = '0;
    for (int j = 0; j < B; j++) r = {r[B-2:0], bitv(k*B - B + j)};
    return r;
  endfunction

  typedef struct packed {
    logic [B-1:0] d;
    int           due;
  } chan_t;

  chan_t        chan_q[$];
  logic [B-1:0] ref_q[$];
  logic [B-1:0] first5 [5];
  int  cyc = 0;
  int  dec_idx = 0;
  int  m_sent = 0, m_skip = 0, done_seen = 0;
  longint m_cnt = 0, m_serr = 0, m_berr = 0;
  bit  m_orphan = 0;
  bit  m_armed = 0;
  longint m_inj = 0;

  bit  chk_en = 0;
  bit  chan_en = 1, chan_drop = 0, stall = 0, rnd_stall = 0, man_dec = 0;
  int  rdy_mode = 0, corrupt = 0;

  // Scoreboard: observes the handshakes and decisions at the clock edge.
  always @(posedge clk) begin
    logic [B-1:0] e;
    bit hs;
    hs = mod_valid && mod_ready;
    if (rst) begin
      ref_q.delete(); chan_q.delete();
      m_sent = 0; m_skip = 0; m_cnt = 0; m_serr = 0; m_berr = 0;
      m_orphan = 0; m_armed = 0; m_inj = 0; dec_idx = 0;
    end else begin
      if (start) begin
        ref_q.delete(); chan_q.delete();
        m_sent = 0; m_skip = 0; m_cnt = 0; m_serr = 0; m_berr = 0;
        m_orphan = 0; m_inj = 0; dec_idx = 0;
      end
      if (dec_valid) begin
        if (chan_en && chan_q.size() > 0) begin
          void'(chan_q.pop_front());
          dec_idx++;
        end
        if (ref_q.size() == 0) m_orphan = 1;
        else begin
          e = ref_q.pop_front();
          if (m_skip < SKIP) m_skip++;
          else begin
            m_cnt++;
            if (e != dec_data) begin
              m_serr++;
              m_berr += $countones(e ^ dec_data);
            end
          end
        end
      end
      if (hs) begin
        if (m_sent < 5) first5[m_sent] = mod_data;
        ref_q.push_back(sym_at(m_sent));
        if (chan_en && !chan_drop) chan_q.push_back('{mod_data, cyc + LAT});
        if (m_armed) m_inj++;
        m_sent++;
      end
`ifdef QAM_LINK_BIST_ERRINJ_EN
      if (inject_err) m_armed = 1;
      else if (hs)    m_armed = 0;
`endif
      if (done) done_seen++;
    end
    cyc++;
  end

  // Compare process.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sym_count", sym_count, m_cnt);
      chk("sym_err", sym_err, m_serr);
      chk("bit_err", bit_err, m_berr);
      chk("orphan", orphan, m_orphan);
      if (mod_valid)
        chk("mod_data", mod_data, sym_at(m_sent) ^ (m_armed ? B'(1) : B'(0)));
`ifdef QAM_LINK_BIST_ERRINJ_EN
      chk("inj_count", inj_count, m_inj);
`endif
    end
  end

  // Modulator-ready and loopback-channel driver.
  initial begin
    logic [B-1:0] mask;
    int ncyc;
    ncyc = 0;
    mod_ready = 0; dec_valid = 0; dec_data = '0;
    forever begin
      @(negedge clk);
      #1;
      ncyc++;
      case (rdy_mode)
        0: mod_ready = 1'b0;
        1: mod_ready = 1'b1;
        2: mod_ready = (ncyc % 3 == 0);
        default: mod_ready = 1'($urandom_range(0, 1));
      endcase
      dec_valid = 1'b0;
      dec_data  = '0;
      if (!chan_en) begin
        dec_valid = man_dec;
      end else if (!stall && chan_q.size() > 0 && chan_q[0].due <= cyc &&
                   !(rnd_stall && $urandom_range(0, 3) == 0)) begin
        mask = '0;
        if (corrupt == 1 && (dec_idx + 1) % 100 == 0) mask = B'(3);
        else if (corrupt == 2 && $urandom_range(0, 7) == 0)
          mask = B'($urandom_range(1, (1 << B) - 1));
        dec_valid = 1'b1;
        dec_data  = chan_q[0].d ^ mask;
      end
    end
  end

  task automatic kick(input int n);
    @(negedge clk);
    start = 1'b1;
    num_syms = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int base,
                           input int budget, output int k);
    k = 0;
    while (done_seen == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_seen == base) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: got no done want done", nm);
    end
    repeat (2) @(negedge clk);
    chk({nm, "_done_once"}, done_seen - base, 1);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic run(input string nm, input int n, input int budget,
                     output int k);
    int base;
    base = done_seen;
    kick(n);
    wait_done(nm, base, budget, k);
  endtask

  initial begin
    int k, n, base;
    for (int i = 0; i < 8192; i++) pb[i] = bitv(i - 15) ^ bitv(i - 14);
    rst = 1; start = 0; num_syms = '0;
`ifdef QAM_LINK_BIST_ERRINJ_EN
    inject_err = 0;
`endif
    repeat (3) @(negedge clk);
    chk_en = 1;
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mod_valid", mod_valid, 0);
    chk("rst_mod_data", mod_data, 0);
    chk("rst_sym_count", sym_count, 0);

    rdy_mode = 1;
    run("ideal", 1000, 6000, k);
    chk("ideal_sym0", first5[0], 4'hF);
    chk("ideal_sym1", first5[1], 4'h0);
    chk("ideal_sym3", first5[3], 4'h0);
    chk("ideal_sym4", first5[4], 4'h2);
    chk("ideal_count", sym_count, 992);
    chk("ideal_serr", sym_err, 0);
    chk("ideal_berr", bit_err, 0);
    chk("ideal_orphan", orphan, 0);

    rdy_mode = 2;
    run("bp", 300, 3000, k);
    chk("bp_count", sym_count, 292);
    chk("bp_serr", sym_err, 0);

    rdy_mode = 1; corrupt = 1;
    run("corrupt", 1000, 6000, k);
    chk("corrupt_count", sym_count, 992);
    chk("corrupt_serr", sym_err, 10);
    chk("corrupt_berr", bit_err, 20);
    corrupt = 0;

    stall = 1;
    base = done_seen;
    kick(40);
    repeat (50) @(negedge clk);
    chk("full_pushes", m_sent, DEPTH);
    chk("full_mod_valid", mod_valid, 0);
    stall = 0;
    wait_done("full", base, 2000, k);
    chk("full_count", sym_count, 32);
    chk("full_serr", sym_err, 0);

    run("zero", 0, 10, k);
    chk("zero_fast", k <= 3, 1);
    chk("zero_count", sym_count, 0);

    chan_drop = 1;
    run("tmo", 5, 1200, k);
    chk("tmo_window", (k >= 1024) && (k <= 1100), 1);
    chk("tmo_count", sym_count, 0);
    chan_drop = 0;

    for (int r = 0; r < 3; r++) begin
      rdy_mode = 3; rnd_stall = 1; corrupt = 2;
      n = $urandom_range(20, 200);
      run("rnd", n, 30 * n + 2000, k);
      chk("rnd_count", sym_count, n - SKIP);
    end
    rdy_mode = 1; rnd_stall = 0; corrupt = 0;

`ifdef QAM_LINK_BIST_ERRINJ_EN
    base = done_seen;
    kick(200);
    repeat (30) @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      inject_err = 1;
      @(negedge clk);
      inject_err = 0;
      repeat (10) @(negedge clk);
    end
    wait_done("inj", base, 3000, k);
    chk("inj_count_lit", inj_count, 5);
    chk("inj_serr", sym_err, 5);
    chk("inj_berr", bit_err, 5);
`endif

    chan_en = 0; rdy_mode = 0;
    kick(20);
    repeat (3) @(negedge clk);
    man_dec = 1;
    @(negedge clk);
    man_dec = 0;
    @(negedge clk);
    chk("orphan_set", orphan, 1);
    rdy_mode = 1;
    repeat (4) @(negedge clk);
    base = done_seen;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("arst_busy", busy, 0);
    chk("arst_mod_valid", mod_valid, 0);
    chk("arst_mod_data", mod_data, 0);
    chk("arst_orphan", orphan, 0);
    chk("arst_sym_count", sym_count, 0);
    repeat (20) @(negedge clk);
    chk("arst_no_done", done_seen - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qam_link_bist.md
Name: qam_link_bist

Overview:
- Parametrised built-in self-test for the QAM mod/demod loopback path.
- Generates PRBS symbols and drives them into the modulator over a valid/ready handshake.
- Stores each sent symbol in a reference FIFO, compares it with the demodulator's sliced decisions, and counts symbol and bit errors.
- Sits beside the loopback top and replaces the fixed 16-QAM 4-bit din stimulus with a width-generic, self-checking source and sink.

Parameters:
- BITS_PER_SYM, 4, bits per symbol (2 = QPSK, 4 = 16-QAM, 6 = 64-QAM); legal values are 2, 4 and 6 only.
- FIFO_DEPTH, 64, reference FIFO entries; must be a power of 2 and ≥ 2× the loopback latency in symbols.
- CNT_W, 32, width of all counters.
- SKIP_SYMS, 8, number of leading decisions discarded while the demodulator settles.

Ports:
- axi_clk  in  1  clock
- axi_rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a test run
- num_syms  in  CNT_W  number of symbols to send (0 = none)
- mod_valid  out  1  symbol valid to modulator
- mod_data  out  BITS_PER_SYM  symbol to modulator (signed, as the din port)
- mod_ready  in  1  modulator accepts symbol
- dec_valid  in  1  demodulated decision valid
- dec_data  in  BITS_PER_SYM  sliced decision
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- sym_count  out  CNT_W  decisions compared
- sym_err  out  CNT_W  symbols with any bit mismatch
- bit_err  out  CNT_W  total mismatched bits
- orphan  out  1  sticky; dec_valid arrived while the FIFO was empty

Behaviour:
- Reset: all outputs are 0. State IDLE. FIFO is emptied. PRBS register = 15'h7FFF.
- PRBS generator:
  - PRBS-15, polynomial x^15+x^14+1.
  - Advances BITS_PER_SYM steps per accepted symbol, i.e. on every mod_valid&&mod_ready.
  - mod_data holds the BITS_PER_SYM newest bits, MSB first.
- States:
  - IDLE:
    - start moves to RUN. Counters, orphan, skip counter and FIFO are cleared; PRBS is reseeded.
    - If num_syms == 0, go straight to DONE.
    - start outside IDLE is ignored.
  - RUN:
    - mod_valid = 1 while sent < num_syms and the FIFO is not full.
    - Each handshake pushes mod_data into the FIFO.
    - mod_data and mod_valid stay stable until mod_ready (AXI-stream rule).
    - Once sent == num_syms, go to DRAIN.
  - DRAIN:
    - mod_valid = 0.
    - Wait until the FIFO is empty, or until 1024 cycles pass with no dec_valid (timeout).
    - Then go to DONE.
  - DONE: done = 1 for one cycle, then IDLE. Counters hold their values until the next start.
- busy = 1 in RUN and DRAIN.
- Compare path:
  - Each dec_valid pops the FIFO head.
  - The first SKIP_SYMS pops are discarded and not counted.
  - For every later pop: sym_count += 1. If the symbol mismatches, sym_err += 1 and bit_err += popcount(head ^ dec_data).
  - Counter outputs are registered, 1-cycle latency after dec_valid.
- Simultaneous FIFO push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A push into a full FIFO is impossible because mod_valid is gated.
- dec_valid with an empty FIFO: set orphan, pop nothing, leave counters unchanged.
- dec_valid outside RUN/DRAIN is ignored.
- Counters saturate at all-ones and do not wrap.
- axi_rst mid-run: abort immediately, return to the reset state, no done pulse.

Optional Feature:
- Macro: QAM_LINK_BIST_ERRINJ_EN.
- With the macro defined:
  - Extra input port inject_err (1 bit).
  - A pulse on inject_err arms a flag. The next accepted symbol is sent with its LSB inverted, but the unmodified symbol is stored in the FIFO.
  - The flag clears on that handshake.
  - Extra output inj_count (CNT_W) counts injected symbols.
- Without the macro: neither port exists and no injection logic is built.

Decomposition:
- Package qam_bist_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - PRBS15 seed constant
  - PRBS15 tap-position constants
  - DRAIN_TIMEOUT = 1024
  - function prbs_step(state, n) returning the advanced register
  - function popcount(symbol)
- One sub-module, qam_ref_fifo: synchronous FIFO of width BITS_PER_SYM and depth FIFO_DEPTH, with full, empty, push and pop.
  - Must handle a simultaneous push and pop when full or when empty.

Test Plan:
- Ideal loopback: BITS_PER_SYM=4, num_syms=1000, decisions = sent symbols after 12 cycles → done pulses; sym_count=992, sym_err=0, bit_err=0, orphan=0.
- Backpressure: mod_ready toggles 1 cycle in every 3 → the sequence matches the unstalled PRBS; zero errors.
- Corrupted channel: the bench XORs 2'b11 into every 100th decision, num_syms=1000 → sym_err=10, bit_err=20.
- FIFO full: FIFO_DEPTH=8, demod stalled for 50 cycles → mod_valid drops after 8 pushes; the run completes with zero errors and no overflow.
- Orphan and reset: inject dec_valid in RUN with the FIFO empty → orphan=1. Then assert axi_rst mid-run → all outputs 0, no done pulse.
- ERRINJ (macro defined): pulse inject_err 5 times → inj_count=5, sym_err=5, bit_err=5.
